// File: rtl/critical_ts_capture.sv
// Taps an AXIS byte stream, timestamps each frame's first beat and queues
// {SOF time, length} for long-enough frames flagged critical by the ethertype checker.
//
// state    | meaning
// IDLE     | between frames, next handshake beat is start-of-frame
// IN_FRAME | counting beats of the current frame until its tlast
module critical_ts_capture #(
  parameter int FIFO_DEPTH    = 8,
  parameter int MIN_FRAME_LEN = 20
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        axis_tvalid,
  input  logic        axis_tready,
  input  logic        axis_tlast,
  input  logic [7:0]  axis_tdata,
  input  logic        is_critical_frame,
  input  logic [63:0] rtc_time,
  output logic        ts_valid,
  input  logic        ts_ready,
  output logic [63:0] ts_data,
  output logic [11:0] ts_len,
  output logic [6:0]  fifo_count,
  output logic [15:0] drop_count
);

  localparam int           PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0]   DEPTH_CNT = 7'(FIFO_DEPTH);
  localparam logic [11:0]  MIN_LEN   = 12'(MIN_FRAME_LEN);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t             state, state_nxt;
  logic [11:0]        byte_cnt, frame_len;
  logic [63:0]        sof_ts;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [75:0]        mem [FIFO_DEPTH];
  logic               beat, eof, qualified, full, push, pop, drop;
  logic               tdata_unused;

  assign tdata_unused = ^axis_tdata;

  assign beat      = axis_tvalid && axis_tready;
  assign frame_len = (byte_cnt == 12'hFFF) ? 12'hFFF : byte_cnt + 12'd1;
  assign eof       = (state == IN_FRAME) && beat && axis_tlast;
  assign qualified = eof && is_critical_frame && (frame_len >= MIN_LEN);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full      = (fifo_count == DEPTH_CNT);
  assign push      = qualified && !full;
  assign drop      = qualified && full;
  assign pop       = ts_valid && ts_ready;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (beat && !axis_tlast) state_nxt = IN_FRAME;
      IN_FRAME: if (beat && axis_tlast)  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      byte_cnt <= '0;
      sof_ts   <= '0;
    end else if (beat) begin
      if (state == IDLE) begin
        sof_ts   <= rtc_time;
        byte_cnt <= 12'd1;
      end else begin
        byte_cnt <= frame_len;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (push) mem[wr_ptr] <= {sof_ts, frame_len};
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 7'd1;
        2'b01:   fifo_count <= fifo_count - 7'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign ts_valid = (fifo_count != 7'd0);
  // Head is forced to zero when empty so it reads clean out of reset.
  assign ts_data  = ts_valid ? mem[rd_ptr][75:12] : 64'd0;
  assign ts_len   = ts_valid ? mem[rd_ptr][11:0]  : 12'd0;

endmodule
